wb_addr_decoder: RTL and testbench
==================================

WB_ADDR_DECODER -- requirements
Module: wb_addr_decoder

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- S0_BASE 32'h0300_0000: slave 0 base
- S1_BASE 32'h0310_0000: slave 1 base
- S2_BASE 32'h0320_0000: slave 2 base
- S3_BASE 32'h0330_0000: slave 3 base
- S_MASK 32'hFFF0_0000: address bits compared against each base
- STAT_BASE 32'h03F0_0000: status register base
- TIMEOUT 8'd255: cycles a slave may take before a bus error is generated
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk in 1: clock
- resetn in 1: synchronous, active-low reset
- m_cyc, m_stb, m_we in 1: master cycle, strobe, write
- m_sel in 4: master byte enables
- m_adr, m_dat_i in 32: master address, write data
- m_ack, m_err out 1: master ack, error flag
- m_dat_o out 32: master read data
- s_cyc, s_stb out 4: per-slave cycle, strobe (one-hot)
- s_we out 1; s_sel out 4; s_adr, s_dat_o out 32: registered copies of the master request, shared by all slaves
- s_ack in 4: per-slave ack
- s_dat_i in 128: slave read data, slave n at [32n+31:32n]
REQ-003 Reset SHALL be resetn, synchronous, active-low; clock SHALL be clk.

Function
REQ-004 States: IDLE, ACTIVE, RESP; one transaction in flight at a time.
REQ-005 In IDLE with m_cyc&m_stb, decode (m_adr&S_MASK)==(Sn_BASE&S_MASK); lowest n wins on overlap.
REQ-006 On a slave hit: register s_adr/s_dat_o/s_we/s_sel and slave index, assert s_cyc[n]/s_stb[n] the next cycle, go to ACTIVE.
REQ-007 In ACTIVE on s_ack[n] of the selected slave: capture s_dat_i slice into m_dat_o, drop s_cyc/s_stb at that edge, assert m_ack for exactly 1 cycle in the cycle after s_ack, m_err=0, go to RESP.
REQ-008 s_ack from non-selected slaves, and s_ack outside ACTIVE, SHALL be ignored.
REQ-009 Timeout counter (8 bit) clears on ACTIVE entry and increments each ACTIVE cycle without ack; when it equals TIMEOUT: drop strobes, m_ack=1 and m_err=1 for 1 cycle, m_dat_o=32'hBADB_AD00, go to RESP.
REQ-010 Status hit ((m_adr&S_MASK)==(STAT_BASE&S_MASK)): no slave strobe; m_ack for 1 cycle the cycle after request; offset 0x0 reads {16'h0, err_count}, 0x4 reads err_addr, others read 0; write to 0x0 clears err_count; other writes ignored.
REQ-011 No hit: no slave strobe; m_ack=m_err=1 for 1 cycle the cycle after request, m_dat_o=32'hBADB_AD00.
REQ-012 Every error (timeout or no hit) SHALL increment err_count (16 bit, saturates at 16'hFFFF) and load err_addr with the failing address; a status write clearing err_count in the same cycle as an error is impossible (single outstanding transaction).
REQ-013 RESP lasts 1 cycle, then IDLE; requests are not sampled in RESP.
REQ-014 Abort: m_cyc low in ACTIVE SHALL drop all strobes at the next edge, return to IDLE, produce no m_ack, and not count an error.
REQ-015 m_dat_o SHALL hold its last value outside ack cycles; m_ack and m_err SHALL never be high outside the single response cycle.

Reset
REQ-016 resetn low at a clock edge SHALL force IDLE, s_cyc=s_stb=0, m_ack=m_err=0, m_dat_o=0, s_adr=s_dat_o=0, s_we=0, s_sel=0, counter=0, err_count=0, err_addr=0, including mid-transaction.

Verification
REQ-017 Read 0x0310_0004; slave 1 acks 3 cycles after strobe with 0x1234_5678 -> s_stb=4'b0010 for 3 cycles, m_ack one cycle later with m_dat_o=0x1234_5678, m_err=0.
REQ-018 Write 0x0300_0000 data 0xA5, sel 4'b0001 -> s_stb=4'b0001, s_dat_o=0xA5, s_sel=1, s_we=1; slave 0 acks -> single m_ack.
REQ-019 Read 0x0330_0000, slave 3 never acks -> strobes drop after 255 cycles, m_ack=m_err=1, data 0xBADB_AD00; status 0x03F0_0000 reads 1, 0x03F0_0004 reads 0x0330_0000.
REQ-020 Read 0x0400_0000 -> m_ack=m_err=1 next cycle, no s_stb; err_count increments; write 0x03F0_0000 -> err_count reads 0.
REQ-021 resetn low during ACTIVE with slave 2 strobed -> s_stb=0 next cycle, no m_ack; later ack from slave 2 ignored.
REQ-022 m_cyc dropped in ACTIVE -> strobes low next edge, IDLE, err_count unchanged.

Source files
------------

// File: rtl/wb_addr_decoder.sv
// Wishbone address decoder: routes one master to four slaves plus an
// internal status block, with per-transaction timeout and error logging.
module wb_addr_decoder #(
    parameter logic [31:0] S0_BASE   = 32'h0300_0000,
    parameter logic [31:0] S1_BASE   = 32'h0310_0000,
    parameter logic [31:0] S2_BASE   = 32'h0320_0000,
    parameter logic [31:0] S3_BASE   = 32'h0330_0000,
    parameter logic [31:0] S_MASK    = 32'hFFF0_0000,
    parameter logic [31:0] STAT_BASE = 32'h03F0_0000,
    parameter logic [7:0]  TIMEOUT   = 8'd255
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          m_cyc,
    input  logic          m_stb,
    input  logic          m_we,
    input  logic [3:0]    m_sel,
    input  logic [31:0]   m_adr,
    input  logic [31:0]   m_dat_i,
    output logic          m_ack,
    output logic          m_err,
    output logic [31:0]   m_dat_o,
    output logic [3:0]    s_cyc,
    output logic [3:0]    s_stb,
    output logic          s_we,
    output logic [3:0]    s_sel,
    output logic [31:0]   s_adr,
    output logic [31:0]   s_dat_o,
    input  logic [3:0]    s_ack,
    input  logic [127:0]  s_dat_i
);

    localparam int unsigned DW       = 32;
    localparam int unsigned CNT_W    = 8;
    localparam int unsigned ECNT_W   = 16;
    localparam logic [31:0] BAD_DATA = 32'hBADB_AD00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_RESP
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         sel_idx_q, sel_idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         stb_q, stb_d;
    logic               s_we_q, s_we_d;
    logic [3:0]         s_sel_q, s_sel_d;
    logic [DW-1:0]      s_adr_q, s_adr_d;
    logic [DW-1:0]      s_dat_q, s_dat_d;
    logic               m_ack_q, m_ack_d;
    logic               m_err_q, m_err_d;
    logic [DW-1:0]      m_dat_q, m_dat_d;
    logic [ECNT_W-1:0]  err_count_q, err_count_d;
    logic [DW-1:0]      err_addr_q, err_addr_d;

    logic [3:0]         slv_hit_vec;
    logic               slv_hit;
    logic [1:0]         slv_idx;
    logic               stat_hit;
    logic [DW-1:0]      stat_off;
    logic [DW-1:0]      stat_rdata;
    logic [ECNT_W-1:0]  err_count_inc;
    logic [CNT_W-1:0]   cnt_inc;

    assign m_ack   = m_ack_q;
    assign m_err   = m_err_q;
    assign m_dat_o = m_dat_q;
    assign s_cyc   = stb_q;
    assign s_stb   = stb_q;
    assign s_we    = s_we_q;
    assign s_sel   = s_sel_q;
    assign s_adr   = s_adr_q;
    assign s_dat_o = s_dat_q;

    // Address decode with lowest-index priority on overlapping windows
    always_comb begin
        slv_hit_vec[0] = (m_adr & S_MASK) == (S0_BASE & S_MASK);
        slv_hit_vec[1] = (m_adr & S_MASK) == (S1_BASE & S_MASK);
        slv_hit_vec[2] = (m_adr & S_MASK) == (S2_BASE & S_MASK);
        slv_hit_vec[3] = (m_adr & S_MASK) == (S3_BASE & S_MASK);
        slv_hit        = |slv_hit_vec;
        if (slv_hit_vec[0])      slv_idx = 2'd0;
        else if (slv_hit_vec[1]) slv_idx = 2'd1;
        else if (slv_hit_vec[2]) slv_idx = 2'd2;
        else                     slv_idx = 2'd3;
        stat_hit = (m_adr & S_MASK) == (STAT_BASE & S_MASK);
        stat_off = m_adr & ~S_MASK;
    end

    // Status register read mux and saturating error-count increment
    always_comb begin
        stat_rdata = '0;
        if (stat_off == 32'h0)      stat_rdata = {16'h0, err_count_q};
        else if (stat_off == 32'h4) stat_rdata = err_addr_q;
        err_count_inc = (err_count_q == 16'hFFFF) ? err_count_q : err_count_q + 16'd1;
        cnt_inc       = cnt_q + 8'd1;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        sel_idx_d   = sel_idx_q;
        cnt_d       = cnt_q;
        stb_d       = stb_q;
        s_we_d      = s_we_q;
        s_sel_d     = s_sel_q;
        s_adr_d     = s_adr_q;
        s_dat_d     = s_dat_q;
        m_ack_d     = 1'b0;
        m_err_d     = 1'b0;
        m_dat_d     = m_dat_q;
        err_count_d = err_count_q;
        err_addr_d  = err_addr_q;

        case (state_q)
            ST_IDLE: begin
                if (m_cyc && m_stb) begin
                    if (slv_hit) begin
                        s_adr_d   = m_adr;
                        s_dat_d   = m_dat_i;
                        s_we_d    = m_we;
                        s_sel_d   = m_sel;
                        sel_idx_d = slv_idx;
                        stb_d     = 4'b0001 << slv_idx;
                        cnt_d     = '0;
                        state_d   = ST_ACTIVE;
                    end else if (stat_hit) begin
                        m_ack_d = 1'b1;
                        state_d = ST_RESP;
                        if (!m_we) begin
                            m_dat_d = stat_rdata;
                        end else if (stat_off == 32'h0) begin
                            err_count_d = '0;
                        end
                    end else begin
                        m_ack_d     = 1'b1;
                        m_err_d     = 1'b1;
                        m_dat_d     = BAD_DATA;
                        err_count_d = err_count_inc;
                        err_addr_d  = m_adr;
                        state_d     = ST_RESP;
                    end
                end
            end
            ST_ACTIVE: begin
                if (!m_cyc) begin
                    // Master abort: silent return, no response, no error logged
                    stb_d   = '0;
                    state_d = ST_IDLE;
                end else if (s_ack[sel_idx_q]) begin
                    m_dat_d = s_dat_i[{sel_idx_q, 5'd0} +: DW];
                    stb_d   = '0;
                    m_ack_d = 1'b1;
                    state_d = ST_RESP;
                end else if (cnt_inc == TIMEOUT) begin
                    stb_d       = '0;
                    m_ack_d     = 1'b1;
                    m_err_d     = 1'b1;
                    m_dat_d     = BAD_DATA;
                    err_count_d = err_count_inc;
                    err_addr_d  = s_adr_q;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                stb_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            sel_idx_q   <= '0;
            cnt_q       <= '0;
            stb_q       <= '0;
            s_we_q      <= 1'b0;
            s_sel_q     <= '0;
            s_adr_q     <= '0;
            s_dat_q     <= '0;
            m_ack_q     <= 1'b0;
            m_err_q     <= 1'b0;
            m_dat_q     <= '0;
            err_count_q <= '0;
            err_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            sel_idx_q   <= sel_idx_d;
            cnt_q       <= cnt_d;
            stb_q       <= stb_d;
            s_we_q      <= s_we_d;
            s_sel_q     <= s_sel_d;
            s_adr_q     <= s_adr_d;
            s_dat_q     <= s_dat_d;
            m_ack_q     <= m_ack_d;
            m_err_q     <= m_err_d;
            m_dat_q     <= m_dat_d;
            err_count_q <= err_count_d;
            err_addr_q  <= err_addr_d;
        end
    end

endmodule

// File: tb/tb_wb_addr_decoder.sv
// Scoreboard bench for wb_addr_decoder: directed cases plus random traffic
// checked against a transaction-level model of the address map.
module tb_wb_addr_decoder;

    localparam logic [31:0] S_MASK    = 32'hFFF0_0000;
    localparam logic [31:0] STAT_BASE = 32'h03F0_0000;
    localparam logic [31:0] BAD       = 32'hBADB_AD00;
    localparam int          TMO       = 255;
    localparam int          NEVER     = 100000;

    logic          clk;
    logic          resetn;
    logic          m_cyc, m_stb, m_we;
    logic [3:0]    m_sel;
    logic [31:0]   m_adr, m_dat_i;
    logic          m_ack, m_err;
    logic [31:0]   m_dat_o;
    logic [3:0]    s_cyc, s_stb;
    logic          s_we;
    logic [3:0]    s_sel;
    logic [31:0]   s_adr, s_dat_o;
    logic [3:0]    s_ack;
    logic [127:0]  s_dat_i;

    wb_addr_decoder dut (
        .clk(clk), .resetn(resetn),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_sel(m_sel),
        .m_adr(m_adr), .m_dat_i(m_dat_i),
        .m_ack(m_ack), .m_err(m_err), .m_dat_o(m_dat_o),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_sel(s_sel),
        .s_adr(s_adr), .s_dat_o(s_dat_o),
        .s_ack(s_ack), .s_dat_i(s_dat_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          err;
        bit          chk_dat;
        logic [31:0] dat;
        logic [3:0]  stb_mask;
        int          stb_cnt;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    logic [31:0] bases [4] = '{32'h0300_0000, 32'h0310_0000, 32'h0320_0000, 32'h0330_0000};
    logic [15:0] mdl_errcnt;
    logic [31:0] mdl_erraddr;
    logic [31:0] slv_data [4];
    int          slv_delay [4];
    int          scnt [4];
    bit          noise_en;
    logic [3:0]  inj_ack;
    logic [31:0] exp_adr, exp_dat;
    logic        exp_we;
    logic [3:0]  exp_sel;
    int          stb_cnt;
    logic [3:0]  stb_seen;
    logic [31:0] hold_ref;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Which region an address falls in: 0..3 slave, 4 status, -1 unmapped
    function automatic int target(input logic [31:0] a);
        for (int n = 0; n < 4; n++)
            if ((a & S_MASK) == (bases[n] & S_MASK)) return n;
        if ((a & S_MASK) == (STAT_BASE & S_MASK)) return 4;
        return -1;
    endfunction

    // Slave models: ack after a programmed number of strobe cycles, plus noise acks
    always @(negedge clk) begin
        logic [3:0] a;
        logic [3:0] noise;
        a = 4'b0;
        for (int n = 0; n < 4; n++) begin
            if (s_stb[n] === 1'b1) begin
                scnt[n]++;
                if (scnt[n] == slv_delay[n]) a[n] = 1'b1;
            end else begin
                scnt[n] = 0;
            end
        end
        noise = noise_en ? (4'($urandom) & 4'($urandom) & ~s_stb) : 4'b0;
        s_ack = a | noise | inj_ack;
        for (int n = 0; n < 4; n++)
            s_dat_i[32*n +: 32] = a[n] ? slv_data[n] : $urandom;
    end

    // Monitor: pops the scoreboard on every master ack
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (resetn !== 1'b1) begin
            stb_cnt  = 0;
            stb_seen = 4'b0;
            hold_ref = 32'h0;
        end else begin
            check("s_cyc_eq_s_stb", 32'(s_cyc), 32'(s_stb));
            if (m_err && !m_ack) check("err_without_ack", 32'(m_err), 32'd0);
            if (s_stb != 4'b0) begin
                stb_cnt++;
                stb_seen |= s_stb;
                if (stb_cnt == 1) begin
                    check("s_adr", s_adr, exp_adr);
                    check("s_dat_o", s_dat_o, exp_dat);
                    check("s_we", 32'(s_we), 32'(exp_we));
                    check("s_sel", 32'(s_sel), 32'(exp_sel));
                end
            end
            if (m_ack) begin
                check("ack_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("m_err", 32'(m_err), 32'(e.err));
                    if (e.chk_dat) check("m_dat_o", m_dat_o, e.dat);
                    check("stb_mask", 32'(stb_seen), 32'(e.stb_mask));
                    check("stb_cycles", 32'(stb_cnt), 32'(e.stb_cnt));
                end
                hold_ref = m_dat_o;
                stb_cnt  = 0;
                stb_seen = 4'b0;
            end else begin
                if (m_dat_o !== hold_ref) check("m_dat_o_hold", m_dat_o, hold_ref);
                if (s_stb == 4'b0) begin
                    stb_cnt  = 0;
                    stb_seen = 4'b0;
                end
            end
        end
    end

    // One complete master transaction; expected response derived from the address map
    task automatic txn(input logic [31:0] addr, input bit we, input logic [31:0] dat,
                       input logic [3:0] sel, input int delay);
        exp_t        e;
        int          t;
        int          lat;
        int          exp_lat;
        logic [31:0] off;
        t = target(addr);
        e.err = 1'b0; e.chk_dat = 1'b0; e.dat = 32'h0; e.stb_mask = 4'b0; e.stb_cnt = 0;
        if (t >= 0 && t < 4) begin
            slv_delay[t] = delay;
            slv_data[t]  = $urandom;
            e.chk_dat    = 1'b1;
            e.stb_mask   = 4'b0001 << t;
            if (delay <= TMO) begin
                e.dat     = slv_data[t];
                e.stb_cnt = delay;
            end else begin
                e.err       = 1'b1;
                e.dat       = BAD;
                e.stb_cnt   = TMO;
                mdl_errcnt  = (mdl_errcnt == 16'hFFFF) ? mdl_errcnt : mdl_errcnt + 16'd1;
                mdl_erraddr = addr;
            end
            exp_lat = e.stb_cnt + 1;
        end else if (t == 4) begin
            off = addr & ~S_MASK;
            if (!we) begin
                e.chk_dat = 1'b1;
                e.dat = (off == 0) ? {16'h0, mdl_errcnt} : (off == 4) ? mdl_erraddr : 32'h0;
            end else if (off == 0) begin
                mdl_errcnt = 16'h0;
            end
            exp_lat = 1;
        end else begin
            e.err = 1'b1; e.chk_dat = 1'b1; e.dat = BAD;
            mdl_errcnt  = (mdl_errcnt == 16'hFFFF) ? mdl_errcnt : mdl_errcnt + 16'd1;
            mdl_erraddr = addr;
            exp_lat = 1;
        end
        exp_q.push_back(e);
        exp_adr = addr; exp_dat = dat; exp_we = we; exp_sel = sel;
        @(negedge clk);
        m_cyc = 1'b1; m_stb = 1'b1; m_we = we; m_sel = sel; m_adr = addr; m_dat_i = dat;
        lat = 0;
        while (1) begin
            @(negedge clk);
            lat++;
            if (m_ack === 1'b1 || lat > 600) break;
        end
        check("ack_latency", 32'(lat), 32'(exp_lat));
        m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
        if (t >= 0 && t < 4) slv_delay[t] = NEVER;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          r;
        resetn = 1'b0; m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
        m_sel = 4'b0; m_adr = 32'h0; m_dat_i = 32'h0;
        inj_ack = 4'b0; noise_en = 1'b1;
        mdl_errcnt = 16'h0; mdl_erraddr = 32'h0;
        for (int n = 0; n < 4; n++) begin
            slv_delay[n] = NEVER; slv_data[n] = 32'h0; scnt[n] = 0;
        end
        repeat (3) @(negedge clk);
        check("rst_m_ack", 32'(m_ack), 32'd0);
        check("rst_m_err", 32'(m_err), 32'd0);
        check("rst_m_dat_o", m_dat_o, 32'h0);
        check("rst_s_stb", 32'(s_stb), 32'd0);
        check("rst_s_cyc", 32'(s_cyc), 32'd0);
        check("rst_s_adr", s_adr, 32'h0);
        check("rst_s_dat_o", s_dat_o, 32'h0);
        check("rst_s_we_sel", 32'({s_we, s_sel}), 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // Slave read, slave write, timeout, status, unmapped
        txn(32'h0310_0004, 1'b0, 32'h0, 4'hF, 3);
        txn(32'h0300_0000, 1'b1, 32'h0000_00A5, 4'b0001, 2);
        txn(32'h0330_0000, 1'b0, 32'h0, 4'hF, NEVER);
        txn(STAT_BASE, 1'b0, 32'h0, 4'hF, 1);
        check("errcnt_after_timeout", {16'h0, mdl_errcnt}, 32'd1);
        txn(STAT_BASE | 32'h4, 1'b0, 32'h0, 4'hF, 1);
        txn(32'h0400_0000, 1'b0, 32'h0, 4'hF, 1);
        txn(STAT_BASE, 1'b0, 32'h0, 4'hF, 1);
        txn(STAT_BASE, 1'b1, 32'h0, 4'hF, 1);
        txn(STAT_BASE, 1'b0, 32'h0, 4'hF, 1);
        txn(STAT_BASE | 32'h8, 1'b0, 32'h0, 4'hF, 1);
        // Timeout boundary: ack on the last allowed cycle wins, one later loses
        txn(32'h0300_0010, 1'b0, 32'h0, 4'hF, TMO);
        txn(32'h0320_0020, 1'b0, 32'h0, 4'hF, TMO + 1);
        txn(STAT_BASE | 32'h4, 1'b0, 32'h0, 4'hF, 1);

        // Master abort during ACTIVE
        exp_adr = 32'h0310_0040; exp_dat = 32'h1111_2222; exp_we = 1'b0; exp_sel = 4'hF;
        m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0; m_sel = 4'hF;
        m_adr = 32'h0310_0040; m_dat_i = 32'h1111_2222;
        repeat (4) @(negedge clk);
        check("abort_stb_before", 32'(s_stb), 32'b0010);
        m_cyc = 1'b0; m_stb = 1'b0;
        @(negedge clk);
        check("abort_stb_after", 32'(s_stb), 32'd0);
        check("abort_cyc_after", 32'(s_cyc), 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("abort_no_ack", 32'(m_ack), 32'd0);
        end
        txn(STAT_BASE, 1'b0, 32'h0, 4'hF, 1);

        // Reset while slave 2 is strobed
        exp_adr = 32'h0320_0000; exp_dat = 32'h0; exp_we = 1'b0; exp_sel = 4'hF;
        m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0; m_sel = 4'hF;
        m_adr = 32'h0320_0000; m_dat_i = 32'h0;
        repeat (4) @(negedge clk);
        check("rst_mid_stb_before", 32'(s_stb), 32'b0100);
        resetn = 1'b0;
        @(negedge clk);
        check("rst_mid_stb_after", 32'(s_stb), 32'd0);
        check("rst_mid_no_ack", 32'(m_ack), 32'd0);
        check("rst_mid_dat", m_dat_o, 32'h0);
        resetn = 1'b1; m_cyc = 1'b0; m_stb = 1'b0;
        mdl_errcnt = 16'h0; mdl_erraddr = 32'h0;
        inj_ack = 4'b0100;
        repeat (3) begin
            @(negedge clk);
            check("late_ack_ignored", 32'(m_ack), 32'd0);
        end
        inj_ack = 4'b0;
        txn(STAT_BASE | 32'h4, 1'b0, 32'h0, 4'hF, 1);

        // Random traffic
        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 9);
            if (r < 6) begin
                a = bases[r % 4] | ($urandom & 32'h000F_FFFC);
            end else if (r < 8) begin
                a = STAT_BASE | (32'($urandom_range(0, 2)) << 2);
            end else begin
                a = $urandom & 32'hFFFF_FFFC;
                while (target(a) != -1) a = $urandom & 32'hFFFF_FFFC;
            end
            txn(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom),
                ($urandom_range(0, 49) == 0) ? NEVER : $urandom_range(1, 6));
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
